// File: rtl/scoreboard_wb_ctrl_if.sv
// Issue, functional-unit writeback and scoreboard status bundle for scoreboard_wb_ctrl.
interface scoreboard_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_FU = 3
);
  localparam int NUM_REGS = 1 << REG_AW;

  logic                     issue_valid;
  logic [1:0]               issue_fu;
  logic [REG_AW-1:0]        issue_dest;
  logic [REG_AW-1:0]        issue_rs;
  logic [REG_AW-1:0]        issue_rt;
  logic                     issue_stall;
  logic [NUM_FU-1:0]        fu_req;
  logic [NUM_FU*REG_AW-1:0] fu_dest;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]        fu_gnt;
  logic                     wb_enable;
  logic [REG_AW-1:0]        wb_dest;
  logic [DATA_W-1:0]        wb_data;
  logic [NUM_REGS-1:0]      reg_busy;
  logic [NUM_FU-1:0]        fu_busy;

  modport master (
    output issue_valid, issue_fu, issue_dest, issue_rs, issue_rt,
    output fu_req, fu_dest, fu_data,
    input  issue_stall, fu_gnt, wb_enable, wb_dest, wb_data, reg_busy, fu_busy
  );

  modport slave (
    input  issue_valid, issue_fu, issue_dest, issue_rs, issue_rt,
    input  fu_req, fu_dest, fu_data,
    output issue_stall, fu_gnt, wb_enable, wb_dest, wb_data, reg_busy, fu_busy
  );
endinterface

// File: rtl/scoreboard_wb_ctrl.sv
// Scoreboard with round-robin writeback arbitration: tracks busy FUs and pending
// destination registers, stalls hazardous issue, and forwards one FU result per
// cycle to the register-file write port through a registered stage.
module scoreboard_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_FU = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  scoreboard_wb_ctrl_if.slave   bus
);
  localparam int NUM_REGS = 1 << REG_AW;

  logic [NUM_FU-1:0]   fu_busy_q,   fu_busy_d;
  logic [NUM_REGS-1:0] reg_busy_q,  reg_busy_d;
  logic [1:0]          rr_ptr_q,    rr_ptr_d;
  logic                wb_enable_q, wb_enable_d;
  logic [REG_AW-1:0]   wb_dest_q,   wb_dest_d;
  logic [DATA_W-1:0]   wb_data_q,   wb_data_d;

  logic                fu_sel_busy_s;
  logic                fu_id_bad_s;
  logic                issue_stall_s;
  logic                issue_accept_s;
  logic [NUM_FU-1:0]   elig_s;
  logic [NUM_FU-1:0]   gnt_s;
  logic                gnt_any_s;
  logic [1:0]          gnt_idx_s;
  logic [REG_AW-1:0]   sel_dest_s;
  logic [DATA_W-1:0]   sel_data_s;

  // FU index reached 'ofs' steps after 'ptr', wrapping at NUM_FU.
  function automatic logic [1:0] rr_index(input logic [1:0] ptr, input int ofs);
    logic [2:0] sum;
    sum = {1'b0, ptr} + 3'(ofs);
    if (sum >= 3'(NUM_FU)) begin
      sum = sum - 3'(NUM_FU);
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Issue hazard detection: bad FU id, busy FU, or any operand/dest still pending.
  always_comb begin
    fu_sel_busy_s = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_sel_busy_s = fu_sel_busy_s | (fu_busy_q[i] & (bus.issue_fu == 2'(i)));
    end
    fu_id_bad_s    = ({30'd0, bus.issue_fu} >= 32'(NUM_FU));
    issue_stall_s  = bus.issue_valid & (fu_id_bad_s | fu_sel_busy_s |
                                        reg_busy_q[bus.issue_dest] |
                                        reg_busy_q[bus.issue_rs] |
                                        reg_busy_q[bus.issue_rt]);
    issue_accept_s = bus.issue_valid & ~issue_stall_s;
  end

  // Round-robin grant among busy FUs that request, plus result selection.
  always_comb begin
    elig_s     = bus.fu_req & fu_busy_q;
    gnt_s      = {NUM_FU{1'b0}};
    gnt_any_s  = 1'b0;
    gnt_idx_s  = 2'd0;
    sel_dest_s = {REG_AW{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_FU; k++) begin
      if (!gnt_any_s && elig_s[rr_index(rr_ptr_q, k)]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = rr_index(rr_ptr_q, k);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      gnt_s[i]   = gnt_any_s & (gnt_idx_s == 2'(i));
      sel_dest_s = sel_dest_s | (bus.fu_dest[i*REG_AW +: REG_AW] & {REG_AW{gnt_s[i]}});
      sel_data_s = sel_data_s | (bus.fu_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
    end
  end

  // Next-state: writeback clears first, then issue sets so a same-edge set wins.
  always_comb begin
    fu_busy_d   = fu_busy_q;
    reg_busy_d  = reg_busy_q;
    rr_ptr_d    = rr_ptr_q;
    wb_enable_d = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    if (wb_enable_q) begin
      reg_busy_d[wb_dest_q] = 1'b0;
    end else begin
      reg_busy_d = reg_busy_d;
    end
    if (gnt_any_s) begin
      fu_busy_d   = fu_busy_d & ~gnt_s;
      rr_ptr_d    = (gnt_idx_s == 2'(NUM_FU - 1)) ? 2'd0 : gnt_idx_s + 2'd1;
      wb_dest_d   = sel_dest_s;
      wb_data_d   = sel_data_s;
      wb_enable_d = (sel_dest_s != {REG_AW{1'b0}});
    end else begin
      wb_enable_d = 1'b0;
    end
    if (issue_accept_s) begin
      for (int i = 0; i < NUM_FU; i++) begin
        fu_busy_d[i] = fu_busy_d[i] | (bus.issue_fu == 2'(i));
      end
      // Register 0 is hardwired, so it never carries a pending write.
      if (bus.issue_dest != {REG_AW{1'b0}}) begin
        reg_busy_d[bus.issue_dest] = 1'b1;
      end else begin
        reg_busy_d = reg_busy_d;
      end
    end else begin
      fu_busy_d = fu_busy_d;
    end
  end

  // State registers; reset overrides any issue or grant in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      fu_busy_q   <= {NUM_FU{1'b0}};
      reg_busy_q  <= {NUM_REGS{1'b0}};
      rr_ptr_q    <= 2'd0;
      wb_enable_q <= 1'b0;
      wb_dest_q   <= {REG_AW{1'b0}};
      wb_data_q   <= {DATA_W{1'b0}};
    end else begin
      fu_busy_q   <= fu_busy_d;
      reg_busy_q  <= reg_busy_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_enable_q <= wb_enable_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign bus.issue_stall = issue_stall_s;
  assign bus.fu_gnt      = gnt_s;
  assign bus.wb_enable   = wb_enable_q;
  assign bus.wb_dest     = wb_dest_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.reg_busy    = reg_busy_q;
  assign bus.fu_busy     = fu_busy_q;
endmodule

// File: doc/scoreboard_wb_ctrl.md
SCOREBOARD_WB_CTRL -- requirements
Module: scoreboard_wb_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, writeback data width.
REQ-002 Parameter REG_AW, default 5, register index width (2^REG_AW registers).
REQ-003 Parameter NUM_FU, default 3, number of functional units; FU ids 0..NUM_FU-1, FU id width 2 bits.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  decode presents an instruction for issue.
REQ-007 issue_fu  in  2  target FU id.
REQ-008 issue_dest  in  REG_AW  destination register.
REQ-009 issue_rs, issue_rt  in  REG_AW each  source registers.
REQ-010 issue_stall  out  1  combinational; instruction must not issue this cycle.
REQ-011 fu_req  in  NUM_FU  per-FU writeback request, held until granted.
REQ-012 fu_dest  in  NUM_FU*REG_AW  packed per-FU destination, FU i at bits [i*REG_AW +: REG_AW].
REQ-013 fu_data  in  NUM_FU*DATA_W  packed per-FU result, same packing.
REQ-014 fu_gnt  out  NUM_FU  combinational one-hot grant, or zero.
REQ-015 wb_enable  out  1  registered register-file write enable.
REQ-016 wb_dest  out  REG_AW  registered write index.
REQ-017 wb_data  out  DATA_W  registered write data.
REQ-018 reg_busy  out  2^REG_AW  pending-write bit per register.
REQ-019 fu_busy  out  NUM_FU  FU-occupied bit per FU.

Function
REQ-020 issue_stall = issue_valid AND (issue_fu >= NUM_FU OR fu_busy[issue_fu] OR reg_busy[issue_dest] OR reg_busy[issue_rs] OR reg_busy[issue_rt]); it is 0 when issue_valid=0.
REQ-021 Issue accepted when issue_valid=1 and issue_stall=0; on that edge fu_busy[issue_fu] sets and, if issue_dest != 0, reg_busy[issue_dest] sets.
REQ-022 Register 0 is never marked busy and never stalls issue.
REQ-023 Eligible requests: fu_req[i] AND fu_busy[i]; requests from non-busy FUs are ignored.
REQ-024 Round-robin arbitration: search starts at rr_ptr, ascending modulo NUM_FU; the first eligible FU is granted, at most one grant per cycle.
REQ-025 On a grant to FU g, rr_ptr <= (g+1) mod NUM_FU; with no grant, rr_ptr holds.
REQ-026 On a grant to FU g, fu_busy[g] clears at that edge; wb_dest/wb_data capture fu_dest/fu_data of g; wb_enable <= 1 if that dest != 0, else 0.
REQ-027 With no grant, wb_enable <= 0 next cycle; wb_dest/wb_data hold.
REQ-028 Writeback latency: grant in cycle N -> wb_enable high during cycle N+1 -> register file commits at end of N+1.
REQ-029 reg_busy[wb_dest] clears on the edge ending a cycle with wb_enable=1, so a dependent instruction issues no earlier than cycle N+2 and reads the committed value.
REQ-030 If a set (REQ-021) and a clear (REQ-029) hit the same reg_busy bit on one edge, set wins.
REQ-031 If an issue to FU i and a grant to FU i occur in the same cycle, the issue is stalled (fu_busy still 1) and the clear takes effect; FU i becomes issuable the next cycle.
REQ-032 fu_busy, reg_busy, rr_ptr, wb_* are the only state; no other storage.

Reset
REQ-033 While reset=1 at an edge: reg_busy=0, fu_busy=0, rr_ptr=0, wb_enable=0, wb_dest=0, wb_data=0.
REQ-034 Reset takes priority over all issue and grant activity in the same cycle; in-flight results are discarded.
REQ-035 Combinational outputs (issue_stall, fu_gnt) reflect the cleared state in the cycle after reset deasserts.

Verification
REQ-036 Issue fu=0 dest=5; next cycle issue rs=5 -> issue_stall=1, reg_busy[5]=1, fu_busy[0]=1.
REQ-037 FU0 req dest=5 data=0xDEADBEEF in cycle N -> fu_gnt=001 in N; wb_enable=1, wb_dest=5, wb_data=0xDEADBEEF in N+1; reg_busy[5]=0 in N+2; rs=5 issue accepted in N+2.
REQ-038 FUs 0,1,2 all busy and requesting continuously from rr_ptr=0 -> grants 001,010,100,... in order, one per cycle, each FU granted once before fu_busy clears.
REQ-039 Issue fu=1 dest=0, then FU1 request -> reg_busy unchanged (all 0), fu_gnt=010, wb_enable=0 next cycle, fu_busy[1]=0.
REQ-040 issue_fu=3 with all state idle -> issue_stall=1, no state change.
REQ-041 reset=1 asserted while FU2 granted and reg_busy[7]=1 -> next cycle wb_enable=0, reg_busy=0, fu_busy=0, rr_ptr=0.
